// File: rtl/timed_assign_sequencer.sv
// Clocked replacement for #-delay assignments: start schedules w/x/y updates and a z snapshot at programmable edges.
// Optional abort input is enabled with `define TAS_ABORT_EN.
module timed_assign_sequencer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef TAS_ABORT_EN
    input  logic          abort,
`endif
    input  logic          a_val,
    input  logic          b_val,
    input  logic          c_val,
    input  logic [CW-1:0] dly_a,
    input  logic [CW-1:0] dly_b,
    input  logic [CW-1:0] dly_c,
    input  logic [CW-1:0] dly_d,
    output logic          busy,
    output logic          done,
    output logic          w,
    output logic          x,
    output logic          y,
    output logic [2:0]    z
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] dly_a_q, dly_a_d, dly_b_q, dly_b_d;
    logic [CW-1:0] dly_c_q, dly_c_d, dly_d_q, dly_d_d;
    logic [CW-1:0] max_q, max_d;
    logic          a_q, a_d, b_q, b_d, c_q, c_d;
    logic          w_q, w_d, x_q, x_d, y_q, y_d;
    logic [2:0]    z_q, z_d;
    logic          done_q, done_d;
    logic [CW-1:0] dly_max_in;
    logic          abort_in;

`ifdef TAS_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    // The sequence ends at the longest delay, so precompute it at launch.
    always_comb begin
        dly_max_in = dly_a;
        if (dly_b > dly_max_in) dly_max_in = dly_b;
        if (dly_c > dly_max_in) dly_max_in = dly_c;
        if (dly_d > dly_max_in) dly_max_in = dly_d;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dly_a_d = dly_a_q;
        dly_b_d = dly_b_q;
        dly_c_d = dly_c_q;
        dly_d_d = dly_d_q;
        max_d   = max_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        w_d     = w_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                    a_d     = a_val;
                    b_d     = b_val;
                    c_d     = c_val;
                    dly_a_d = dly_a;
                    dly_b_d = dly_b;
                    dly_c_d = dly_c;
                    dly_d_d = dly_d;
                    max_d   = dly_max_in;
                end
            end
            RUN: begin
                if (abort_in) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + ONE;
                    if (count_q == dly_a_q) w_d = a_q;
                    if (count_q == dly_b_q) x_d = b_q;
                    if (count_q == dly_c_q) y_d = c_q;
                    // Snapshot takes pre-edge w/x/y, so a same-edge update is not seen.
                    if (count_q == dly_d_q) z_d = {w_q, x_q, y_q};
                    if (count_q == max_q) begin
                        state_d = IDLE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            dly_a_q <= '0;
            dly_b_q <= '0;
            dly_c_q <= '0;
            dly_d_q <= '0;
            max_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            w_q     <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            z_q     <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dly_a_q <= dly_a_d;
            dly_b_q <= dly_b_d;
            dly_c_q <= dly_c_d;
            dly_d_q <= dly_d_d;
            max_q   <= max_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            w_q     <= w_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign w    = w_q;
    assign x    = x_q;
    assign y    = y_q;
    assign z    = z_q;

endmodule
